bcd_down_cnt: RTL

Synchronous, multi-digit BCD down counter (countdown timer), the decrementing counterpart to the team's decade up counter. Loads a BCD preset, decrements by one per enabled clock with borrow ripple across digits, and flags zero and terminal count. Sits beside the up counter in timer and display paths. Exposes a cascade borrow so several instances chain into wider timers.

---
 rtl/bcd_down_cnt_pkg.sv | 13 +
 rtl/bcd_down_cnt_if.sv | 20 ++
 rtl/bcd_down_cnt_digit.sv | 26 ++
 rtl/bcd_down_cnt.sv | 79 +++++++
 4 files changed

// File: rtl/bcd_down_cnt_pkg.sv
// Shared BCD digit type, digit limits and clamp helper for the BCD down counter.
package bcd_down_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_cnt_if.sv
// Control/status bundle of the BCD down counter; master drives preset and enables.
interface bcd_down_cnt_if #(
  parameter int unsigned DIGITS = 2
);
  import bcd_down_pkg::*;

  localparam int unsigned W = 4 * DIGITS;

  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] cnt;
  logic         zero;
  logic         borrow;
  logic         done;

  modport master (output en, load, din, input cnt, zero, borrow, done);
  modport slave  (input en, load, din, output cnt, zero, borrow, done);

endinterface

// File: rtl/bcd_down_cnt_digit.sv
// One BCD digit: load, or decrement on borrow-in with 0 -> 9 wrap; borrow passes on at 0.
module bcd_dn_digit
  import bcd_down_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  bcd_t load_val,
  input  logic borrow_in,
  output bcd_t q,
  output logic borrow_out_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= BCD_ZERO;
    end else if (load) begin
      q <= load_val;
    end else if (borrow_in) begin
      q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
    end
  end

  assign borrow_out_c = borrow_in && (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_cnt.sv
// Multi-digit BCD down counter with zero flag, cascade borrow and done pulse.
// Optional BCD_DCNT_AUTORELOAD_EN: reload from last preset instead of wrapping at zero.
module bcd_down_cnt
  import bcd_down_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  bcd_down_cnt_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  logic [DIGITS:0] brw;
  logic [W-1:0]    cnt_q;
  logic [W-1:0]    din_clamp;
  logic [W-1:0]    load_val;
  logic            reload;
  logic            done_q;
  logic            zero;

  always_comb begin
    din_clamp = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      din_clamp[4*i +: 4] = bcd_clamp(bus.din[4*i +: 4]);
    end
  end

  assign zero = (cnt_q == '0);

`ifdef BCD_DCNT_AUTORELOAD_EN
  logic [W-1:0] preset_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset_q <= '0;
    end else if (bus.load) begin
      preset_q <= din_clamp;
    end
  end

  // At zero an enabled count restarts from the preset rather than borrowing through.
  assign reload   = bus.en && !bus.load && zero;
  assign load_val = bus.load ? din_clamp : preset_q;
`else
  assign reload   = 1'b0;
  assign load_val = din_clamp;
`endif

  assign brw[0] = bus.en;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_dn_digit u_digit (
      .clk          (clk),
      .rst          (rst),
      .load         (bus.load || reload),
      .load_val     (load_val[4*g +: 4]),
      .borrow_in    (brw[g]),
      .q            (cnt_q[4*g +: 4]),
      .borrow_out_c (brw[g+1])
    );
  end

  // Count reaches zero by decrement only from exactly one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= bus.en && !bus.load && (cnt_q == W'(1));
    end
  end

  assign bus.cnt    = cnt_q;
  assign bus.zero   = zero;
  assign bus.borrow = brw[DIGITS] && !bus.load;
  assign bus.done   = done_q;

endmodule
